// File: rtl/hexdisp_pkg.sv
// Shared types and constants for the hex display scroll controller.
// One digit code is 5 bits wide; code 20 drives a blank digit.
package hexdisp_pkg;

  typedef logic [4:0] digit_t;

  localparam digit_t BLANK      = 5'd20;
  localparam int     NUM_DIGITS = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCROLL = 2'd2
  } state_t;

  // Switch view: digit k shows its own index while switch k is on.
  function automatic digit_t sw_digit(input logic on, input int k);
    return on ? digit_t'(k) : BLANK;
  endfunction

endpackage

// File: rtl/hexdisp_scroll_ctrl_sw_debounce.sv
// Switch debouncer: 2-FF synchronizer, shared sample tick and a filter
// that only accepts a new level once two consecutive samples agree.
module sw_debounce #(
  parameter int N          = 10,
  parameter int DEB_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw_db
);

  localparam int            TW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [TW-1:0] TC = TW'(DEB_CYCLES - 1);

  logic [N-1:0]  sync1_q, sync1_d;
  logic [N-1:0]  sync2_q, sync2_d;
  logic [N-1:0]  sample_q, sample_d;
  logic [N-1:0]  sw_db_q, sw_db_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [N-1:0]  agree;
  logic          tick;

  always_comb begin
    sync1_d  = sw_raw;
    sync2_d  = sync1_q;
    tick     = (tmr_q == TC);
    tmr_d    = tick ? '0 : tmr_q + 1'b1;
    sample_d = sample_q;
    sw_db_d  = sw_db_q;
    agree    = ~(sync2_q ^ sample_q);
    if (tick) begin
      sample_d = sync2_q;
      // Bits whose previous and current samples match take the new level.
      sw_db_d  = (agree & sync2_q) | (~agree & sw_db_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sample_q <= '0;
      sw_db_q  <= '0;
      tmr_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sample_q <= sample_d;
      sw_db_q  <= sw_db_d;
      tmr_q    <= tmr_d;
    end
  end

  assign sw_db = sw_db_q;

endmodule

// File: rtl/hexdisp_scroll_ctrl.sv
// Six-digit display controller: shows the debounced switch pattern, or
// buffers a message from a valid/ready stream and scrolls it right-to-left.
module hexdisp_scroll_ctrl
  import hexdisp_pkg::*;
#(
  parameter int DEB_CYCLES  = 50000,
  parameter int STEP_CYCLES = 25000000,
  parameter int MSG_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] stswi,
  input  logic       msg_valid,
  input  logic [4:0] msg_data,
  input  logic       msg_last,
  output logic       msg_ready,
  output logic [9:0] sw_db,
  output logic [4:0] data_0,
  output logic [4:0] data_1,
  output logic [4:0] data_2,
  output logic [4:0] data_3,
  output logic [4:0] data_4,
  output logic [4:0] data_5,
  output logic       busy,
  output state_t     state_dbg
);

  localparam int            CW      = $clog2(MSG_DEPTH + 7);
  localparam int            AW      = $clog2(MSG_DEPTH);
  localparam int            TW      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] STEP_TC = TW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(MSG_DEPTH);

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [CW-1:0]                step_q, step_d;
  logic [TW-1:0]                tmr_q, tmr_d;
  digit_t [NUM_DIGITS-1:0]      data_q, data_d;
  digit_t                       msg_buf_q [MSG_DEPTH];
  logic                         buf_we;
  logic [AW-1:0]                buf_waddr;
  logic                         xfer;
  logic                         abort;

  sw_debounce #(
    .N          (10),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (stswi),
    .sw_db  (sw_db)
  );

  // A beat moves when msg_valid & msg_ready; ready depends only on state
  // (high in IDLE and LOAD), and anything offered while ready is low is dropped.
  assign msg_ready = (state_q != SCROLL);
  assign xfer      = msg_valid & msg_ready;
  assign abort     = sw_db[9];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    tmr_d     = tmr_q;
    data_d    = data_q;
    buf_we    = 1'b0;
    buf_waddr = cnt_q[AW-1:0];
    unique case (state_q)
      IDLE: begin
        for (int k = 0; k < NUM_DIGITS; k++) data_d[k] = sw_digit(sw_db[k], k);
        if (xfer) begin
          buf_we    = 1'b1;
          buf_waddr = '0;
          cnt_d     = CW'(1);
          if (msg_last) begin
            state_d = SCROLL;
            data_d  = {NUM_DIGITS{BLANK}};
            tmr_d   = '0;
            step_d  = '0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (xfer) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          // A full buffer starts scrolling even without msg_last.
          if (msg_last || ((cnt_q + 1'b1) == DEPTH_C)) begin
            state_d = SCROLL;
            data_d  = {NUM_DIGITS{BLANK}};
            tmr_d   = '0;
            step_d  = '0;
          end
        end
      end
      SCROLL: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tmr_q == STEP_TC) begin
          tmr_d = '0;
          for (int k = NUM_DIGITS - 1; k > 0; k--) data_d[k] = data_q[k-1];
          data_d[0] = (step_q < cnt_q) ? msg_buf_q[step_q[AW-1:0]] : BLANK;
          step_d    = step_q + 1'b1;
          // Last digit has left digit 5 once cnt+6 shifts are done.
          if (step_q == (cnt_q + CW'(5))) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      tmr_q   <= '0;
      data_q  <= {NUM_DIGITS{BLANK}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) msg_buf_q[buf_waddr] <= msg_data;
  end

  assign data_0    = data_q[0];
  assign data_1    = data_q[1];
  assign data_2    = data_q[2];
  assign data_3    = data_q[3];
  assign data_4    = data_q[4];
  assign data_5    = data_q[5];
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_hexdisp_scroll_ctrl.sv
// Bench for hexdisp_scroll_ctrl: a cycle model built on message/step-count
// arithmetic is compared every cycle, plus directed literal checks.
module tb_hexdisp_scroll_ctrl;
  import hexdisp_pkg::*;

  localparam int DEB   = 4;
  localparam int STEP  = 3;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] stswi = '0;
  logic       msg_valid = 1'b0;
  logic [4:0] msg_data = '0;
  logic       msg_last = 1'b0;
  logic       msg_ready;
  logic [9:0] sw_db;
  logic [4:0] data_0, data_1, data_2, data_3, data_4, data_5;
  logic       busy;
  state_t     state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hexdisp_scroll_ctrl #(
    .DEB_CYCLES  (DEB),
    .STEP_CYCLES (STEP),
    .MSG_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stswi     (stswi),
    .msg_valid (msg_valid),
    .msg_data  (msg_data),
    .msg_last  (msg_last),
    .msg_ready (msg_ready),
    .sw_db     (sw_db),
    .data_0    (data_0),
    .data_1    (data_1),
    .data_2    (data_2),
    .data_3    (data_3),
    .data_4    (data_4),
    .data_5    (data_5),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode 0 = showing switches, 1 = collecting, 2 = scrolling
  int         m_mode;
  logic [4:0] m_msg[$];
  int         m_cyc;
  int         m_n;
  logic [9:0] m_s1, m_s2, m_smp, m_db;
  logic [4:0] m_disp[6];
  bit         m_valid = 1'b0;

  always @(posedge clk) begin : model
    bit         xfer;
    bit         abort;
    int         s;
    int         idx;
    logic [9:0] old_db;
    if (rst) begin
      m_mode = 0;
      m_msg.delete();
      m_cyc  = 0;
      m_n    = 0;
      m_s1   = '0;
      m_s2   = '0;
      m_smp  = '0;
      m_db   = '0;
      for (int k = 0; k < 6; k++) m_disp[k] = BLANK;
      m_valid = 1'b1;
    end else begin
      old_db = m_db;
      abort  = old_db[9];
      xfer   = msg_valid && (m_mode != 2);
      case (m_mode)
        0: begin
          for (int k = 0; k < 6; k++) m_disp[k] = old_db[k] ? 5'(k) : BLANK;
          if (xfer) begin
            m_msg.delete();
            m_msg.push_back(msg_data);
            if (msg_last) begin
              m_mode = 2;
              m_cyc  = 0;
              for (int k = 0; k < 6; k++) m_disp[k] = BLANK;
            end else begin
              m_mode = 1;
            end
          end
        end
        1: begin
          if (abort) begin
            m_mode = 0;
            m_msg.delete();
          end else if (xfer) begin
            m_msg.push_back(msg_data);
            if (msg_last || m_msg.size() == DEPTH) begin
              m_mode = 2;
              m_cyc  = 0;
              for (int k = 0; k < 6; k++) m_disp[k] = BLANK;
            end
          end
        end
        default: begin
          if (abort) begin
            m_mode = 0;
            m_msg.delete();
          end else begin
            m_cyc++;
            s = m_cyc / STEP;
            for (int k = 0; k < 6; k++) begin
              idx = s - 1 - k;
              m_disp[k] = (idx >= 0 && idx < m_msg.size()) ? m_msg[idx] : BLANK;
            end
            if (s == m_msg.size() + 6) begin
              m_mode = 0;
              m_msg.delete();
            end
          end
        end
      endcase
      if (m_n % DEB == DEB - 1) begin
        for (int i = 0; i < 10; i++) if (m_s2[i] == m_smp[i]) m_db[i] = m_s2[i];
        m_smp = m_s2;
      end
      m_s2 = m_s1;
      m_s1 = stswi;
      m_n++;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("sw_db", 32'(sw_db), 32'(m_db));
      check("data_0", 32'(data_0), 32'(m_disp[0]));
      check("data_1", 32'(data_1), 32'(m_disp[1]));
      check("data_2", 32'(data_2), 32'(m_disp[2]));
      check("data_3", 32'(data_3), 32'(m_disp[3]));
      check("data_4", 32'(data_4), 32'(m_disp[4]));
      check("data_5", 32'(data_5), 32'(m_disp[5]));
      check("busy", 32'(busy), 32'(m_mode != 0));
      check("msg_ready", 32'(msg_ready), 32'(m_mode != 2));
      check("state", 32'(state_dbg), 32'(m_mode));
    end
  end

  // ---------------- monitor ----------------
  int         busy_cnt = 0;
  int         beat_cnt = 0;
  logic [4:0] shown[$];
  logic [4:0] last_d0 = BLANK;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (msg_valid && msg_ready) beat_cnt++;
    if (busy && data_0 != last_d0 && data_0 != BLANK) shown.push_back(data_0);
    last_d0 = data_0;
  end

  // ---------------- driver tasks ----------------
  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [4:0] d, input logic last, input int max_wait,
                           output bit acc);
    msg_valid = 1'b1;
    msg_data  = d;
    msg_last  = last;
    acc       = 1'b0;
    for (int i = 0; i < max_wait && !acc; i++) begin
      @(negedge clk);
      acc = msg_ready;
      @(posedge clk);
      #1;
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit, output int waited);
    waited = 0;
    while (busy && waited < limit) begin
      step_clk(1);
      waited++;
    end
    check(name, 32'(waited < limit), 32'd1);
  endtask

  task automatic check_shown(input string name, input logic [4:0] exp[$]);
    check($sformatf("%s_count", name), 32'(shown.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_%0d", name, i), 32'(i < shown.size() ? shown[i] : 5'h1f), 32'(exp[i]));
  endtask

  task automatic check_all_blank(input string name);
    check({name, "_d0"}, 32'(data_0), 32'd20);
    check({name, "_d1"}, 32'(data_1), 32'd20);
    check({name, "_d2"}, 32'(data_2), 32'd20);
    check({name, "_d3"}, 32'(data_3), 32'd20);
    check({name, "_d4"}, 32'(data_4), 32'd20);
    check({name, "_d5"}, 32'(data_5), 32'd20);
  endtask

  task automatic clear_mon();
    busy_cnt = 0;
    beat_cnt = 0;
    shown.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit         acc;
    int         w;
    logic [4:0] exp_q[$];

    step_clk(3);
    check_all_blank("rst");
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sw_db", 32'(sw_db), 32'd0);
    check("rst_ready", 32'(msg_ready), 32'd1);

    // 1: steady switches 0x00A
    rst   = 1'b0;
    stswi = 10'h00A;
    step_clk(12);
    check("t1_sw_db", 32'(sw_db), 32'h00A);
    check("t1_d0", 32'(data_0), 32'd20);
    check("t1_d1", 32'(data_1), 32'd1);
    check("t1_d2", 32'(data_2), 32'd20);
    check("t1_d3", 32'(data_3), 32'd3);
    check("t1_d4", 32'(data_4), 32'd20);
    check("t1_d5", 32'(data_5), 32'd20);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: one-cycle glitch on switch 0
    stswi = 10'h00B;
    step_clk(1);
    stswi = 10'h00A;
    step_clk(12);
    check("t2_sw_db", 32'(sw_db), 32'h00A);
    check("t2_d0", 32'(data_0), 32'd20);

    stswi = 10'h000;
    step_clk(12);

    // 3: message 3,A,5 with last on the 5
    clear_mon();
    send_beat(5'd3, 1'b0, 4, acc);
    send_beat(5'd10, 1'b0, 4, acc);
    send_beat(5'd5, 1'b1, 4, acc);
    check("t3_ready_after", 32'(msg_ready), 32'd0);
    wait_idle("t3_idle_timeout", 100, w);
    check("t3_beats", 32'(beat_cnt), 32'd3);
    check("t3_busy_cycles", 32'(busy_cnt), 32'd29);
    exp_q = {5'd3, 5'd10, 5'd5};
    check_shown("t3_shown", exp_q);

    // 4: five digits, no last; buffer fills at four
    step_clk(2);
    clear_mon();
    send_beat(5'd1, 1'b0, 4, acc);
    send_beat(5'd2, 1'b0, 4, acc);
    send_beat(5'd3, 1'b0, 4, acc);
    send_beat(5'd4, 1'b0, 4, acc);
    send_beat(5'd5, 1'b0, 5, acc);
    check("t4_fifth_accepted", 32'(acc), 32'd0);
    wait_idle("t4_idle_timeout", 100, w);
    check("t4_beats", 32'(beat_cnt), 32'd4);
    check("t4_busy_cycles", 32'(busy_cnt), 32'd33);
    exp_q = {5'd1, 5'd2, 5'd3, 5'd4};
    check_shown("t4_shown", exp_q);

    // 5: abort with switch 9 while scrolling
    step_clk(2);
    send_beat(5'd8, 1'b0, 4, acc);
    send_beat(5'd9, 1'b1, 4, acc);
    stswi = 10'h200;
    wait_idle("t5_idle_timeout", 40, w);
    check("t5_abort_early", 32'(w < 20), 32'd1);
    step_clk(1);
    check("t5_state", 32'(state_dbg), 32'(IDLE));
    check("t5_sw_db", 32'(sw_db), 32'h200);
    check_all_blank("t5");
    send_beat(5'd6, 1'b0, 4, acc);
    check("t5_idle_accept", 32'(acc), 32'd1);
    step_clk(1);
    check("t5_reabort_state", 32'(state_dbg), 32'(IDLE));
    stswi = 10'h000;
    step_clk(14);

    // 6: reset in the middle of loading
    send_beat(5'd4, 1'b0, 4, acc);
    send_beat(5'd5, 1'b0, 4, acc);
    rst = 1'b1;
    step_clk(1);
    rst = 1'b0;
    check_all_blank("t6");
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_cnt", 32'(dut.cnt_q), 32'd0);
    clear_mon();
    send_beat(5'd7, 1'b1, 4, acc);
    wait_idle("t6_idle_timeout", 60, w);
    check("t6_busy_cycles", 32'(busy_cnt), 32'd21);
    exp_q = {5'd7};
    check_shown("t6_shown", exp_q);

    step_clk(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
